// File: rtl/icache_fetch_mem_responder.sv
// icache_fetch_mem_responder: in-order fetch backing store returning one line per request after a set latency
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   adapter_fetch_mem_req_*           request channel (vld/rdy, byte addr, opaque entry id)
//   adapter_fetch_mem_ack_*           response channel (vld/rdy, line data, echoed entry id)
//   mem_wr_en/mem_wr_idx/mem_wr_data  backdoor line write
// Build option FETCH_MEM_RESP_RANDOM_DELAY_EN adds 0..7 LFSR-driven extra cycles per request.
module icache_fetch_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_W     = 256,
  parameter int ID_W       = 12,
  parameter int QDEPTH     = 8,
  parameter int LATENCY    = 4,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adapter_fetch_mem_req_vld,
  output logic                         adapter_fetch_mem_req_rdy,
  input  logic [ADDR_WIDTH-1:0]        adapter_fetch_mem_req_addr,
  input  logic [ID_W-1:0]              adapter_fetch_mem_req_entry_id,
  output logic                         adapter_fetch_mem_ack_vld,
  input  logic                         adapter_fetch_mem_ack_rdy,
  output logic [DATA_W-1:0]            adapter_fetch_mem_ack_data,
  output logic [ID_W-1:0]              adapter_fetch_mem_ack_entry_id,
  input  logic                         mem_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_wr_idx,
  input  logic [DATA_W-1:0]            mem_wr_data
);
  localparam int LW  = $clog2(MEM_WORDS);
  localparam int OFF = $clog2(DATA_W / 8);
  localparam int QW  = $clog2(QDEPTH);
  localparam int TW  = $clog2(LATENCY + 8) + 1;
  logic [DATA_W-1:0] lines [MEM_WORDS];
  // Each line is its own register so it can carry its power-up pattern without an init process.
  for (genvar i = 0; i < MEM_WORDS; i++) begin : g_line
    logic [DATA_W-1:0] line_q = {DATA_W/32{32'(i)}};
    always_ff @(posedge clk)
      if (mem_wr_en && mem_wr_idx == LW'(i)) line_q <= mem_wr_data;
    assign lines[i] = line_q;
  end
  logic [QDEPTH-1:0] q_v;
  logic [LW-1:0]     q_idx [QDEPTH];
  logic [ID_W-1:0]   q_id  [QDEPTH];
  logic [TW-1:0]     q_tmr [QDEPTH];
  logic [QW-1:0]     wp, rp;
  logic [QW:0]       cnt;
  logic              push, pop;
  logic [TW-1:0]     push_tmr;
  logic              unused_addr;
  assign unused_addr = ^adapter_fetch_mem_req_addr;
`ifdef FETCH_MEM_RESP_RANDOM_DELAY_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    if (rst) lfsr <= 16'hACE1;
    else if (push) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign push_tmr = TW'(LATENCY) + TW'(lfsr[2:0]);
`else
  assign push_tmr = TW'(LATENCY);
`endif
  assign adapter_fetch_mem_req_rdy      = !rst && cnt != (QW+1)'(QDEPTH);
  assign adapter_fetch_mem_ack_vld      = !rst && q_v[rp] && q_tmr[rp] == '0;
  assign adapter_fetch_mem_ack_data     = lines[q_idx[rp]];
  assign adapter_fetch_mem_ack_entry_id = q_id[rp];
  assign push = adapter_fetch_mem_req_vld && adapter_fetch_mem_req_rdy;
  assign pop  = adapter_fetch_mem_ack_vld && adapter_fetch_mem_ack_rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      q_v <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      // All waiting entries age, even those stuck behind a stalled head.
      for (int k = 0; k < QDEPTH; k++)
        if (q_v[k] && q_tmr[k] != '0) q_tmr[k] <= q_tmr[k] - 1'b1;
      if (push) begin
        q_v[wp]   <= 1'b1;
        q_idx[wp] <= adapter_fetch_mem_req_addr[OFF +: LW];
        q_id[wp]  <= adapter_fetch_mem_req_entry_id;
        q_tmr[wp] <= push_tmr;
        wp        <= wp + 1'b1;
      end
      if (pop) begin
        q_v[rp] <= 1'b0;
        rp      <= rp + 1'b1;
      end
      cnt <= cnt + (QW+1)'(push) - (QW+1)'(pop);
    end
  end
endmodule
